pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline-stage register: the successor to the fixed-field, enable/flush-only inter-stage latches between the processor's pipeline stages. It carries an arbitrary-width payload across a stage boundary with a valid/ready handshake, a two-entry skid buffer, a fully registered `in_ready`, synchronous flush to a bubble and a saturating stall-cycle counter. Each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) is one instance with its packed field bundle as payload.

## Interface
Parameters:
- `WIDTH`, 32, payload width in bits (≥1)
- `CNTW`, 16, stall counter width in bits (≥1)

Ports:
- `CLK`  in  1  single clock, all state updates on rising edge
- `nRST`  in  1  reset, asynchronous, active-low
- `flush`  in  1  synchronous squash of all held entries
- `in_valid`  in  1  upstream offers `in_data`
- `in_ready`  out  1  stage accepts; driven directly from a flop
- `in_data`  in  WIDTH  upstream payload
- `out_valid`  out  1  `out_data` holds a live entry
- `out_ready`  in  1  downstream accepts
- `out_data`  out  WIDTH  payload at head of stage, driven directly from a flop
- `occupancy`  out  2  live entries, 0..2
- `stall_cnt`  out  CNTW  cycles with `out_valid && !out_ready`, saturating

## Operation
- Storage: `main` register (drives `out_data`), `skid` register, state ∈ {EMPTY, ONE, FULL}.
- `in_fire = in_valid && in_ready`; `out_fire = out_valid && out_ready`.
- `in_ready = (state != FULL)`, registered. `out_valid = (state != EMPTY)`. `occupancy` = 0/1/2 for EMPTY/ONE/FULL.
- EMPTY: `in_fire` → `main <= in_data`, ONE; else hold.
- ONE: `in_fire && out_fire` → `main <= in_data`, stay ONE. `in_fire && !out_fire` → `skid <= in_data`, FULL. `!in_fire && out_fire` → EMPTY. Neither → hold.
- FULL: `out_fire` → `main <= skid`, ONE. `in_fire` cannot occur.
- Ordering is strict FIFO. No entry is lost or duplicated.
- `flush`: highest priority. Next state EMPTY. `main` and `skid` go to 0. Any `in_fire` or `out_fire` in the same cycle is ignored for state purposes. The downstream may still have sampled `out_data` that cycle, which is the consumer's responsibility. `in_ready` is 1 the following cycle.
- `stall_cnt`: +1 each cycle `out_valid && !out_ready`, independent of `flush`. Holds at 2^CNTW−1. Cleared only by reset.
- `in_data` is ignored when `in_ready` = 0. `out_data` is 0 whenever EMPTY after reset or flush. After a normal drain, `main` retains the last value (don't-care while `out_valid` = 0).

## Timing
- Reset (`nRST` = 0, asynchronous, immediate): state EMPTY, `out_valid` 0, `in_ready` 1, `out_data` 0, skid 0, `occupancy` 0, `stall_cnt` 0. Release is synchronous to the next `CLK` edge. Reset mid-transfer discards all entries.
- Latency: an entry accepted at edge N is visible on `out_valid`/`out_data` after edge N, i.e. 1 cycle.
- Throughput: 1 entry/cycle sustained while `out_ready` = 1.
- Backpressure: when `out_ready` drops while ONE, the stage absorbs exactly one more entry (FULL). `in_ready` falls the cycle after entering FULL, never combinationally from `out_ready`.
- Resume from FULL: `out_ready` = 1 drains `main` and promotes `skid` at the same edge. `in_ready` rises the next cycle.
- Simultaneous `flush` and `nRST` = 0: reset wins. Reset values also equal the flush values, except `stall_cnt`.

## Test plan
- Reset: assert `nRST` = 0 mid-stream with `occupancy` = 2 → all outputs at reset values immediately, before any edge. After release, first `in_valid` = 1 with 0xDEADBEEF appears on `out_data` one cycle later.
- Streaming: `out_ready` held 1, push 0x1..0x64 back-to-back → 100 outputs in order, one per cycle, 1-cycle latency, `in_ready` never 0, `stall_cnt` = 0.
- Skid: push 0xA, 0xB, 0xC continuously; drop `out_ready` when 0xA is at the output → 0xB is captured in skid, `in_ready` = 0, `occupancy` = 2, 0xC held upstream. Raise `out_ready` → outputs 0xA, 0xB, 0xC in order, none lost or duplicated.
- Flush: FULL with 0x11/0x22, assert `flush` together with `in_valid` = 1 carrying 0x33 → next cycle `out_valid` 0, `out_data` 0, `occupancy` 0, `in_ready` 1. 0x33 is never output.
- Stall counter: `CNTW` = 3, hold `out_valid` = 1 with `out_ready` = 0 for 10 cycles → `stall_cnt` reads 1..7, then stays 7. Flush does not clear it.
- Randomised `in_valid`/`out_ready` over 10k cycles against a scoreboard → exact order match, `occupancy` ≤ 2, `in_ready` == (`occupancy` != 2).

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready stage, 2-entry skid, registered in_ready, flush, saturating stall count (CLK/nRST, flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data, occupancy, stall_cnt)
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter int CNTW = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNTW-1:0]  stall_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] main_q, skid_q, main_nx, skid_nx;
  logic in_fire, out_fire;
  assign out_data = main_q;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      state    <= state_nx;
      in_ready <= state_nx != FULL;
      main_q   <= main_nx;
      skid_q   <= skid_nx;
    end
  always_comb begin
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    state_nx = flush ? EMPTY :
               state == EMPTY ? (in_fire ? ONE : EMPTY) :
               state == ONE ? (in_fire && !out_fire ? FULL : !in_fire && out_fire ? EMPTY : ONE) :
               (out_fire ? ONE : FULL);
    main_nx  = flush ? '0 :
               (state == EMPTY && in_fire) || (state == ONE && in_fire && out_fire) ? in_data :
               (state == FULL && out_fire) ? skid_q : main_q;
    skid_nx  = flush ? '0 : (state == ONE && in_fire && !out_fire) ? in_data : skid_q;
  end
  always_comb begin
    out_valid = state != EMPTY;
    occupancy = {state == FULL, state == ONE};
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized and directed checks of pipe_stage_reg against a 2-deep queue model
module tb_pipe_stage_reg;
  logic CLK = 1'b0;
  logic nRST, flush, in_valid, out_ready, in_ready, out_valid;
  logic [31:0] in_data, out_data;
  logic [1:0] occupancy;
  logic [15:0] stall_cnt;
  logic s_flush, s_in_valid, s_out_ready, s_in_ready, s_out_valid;
  logic [31:0] s_in_data, s_out_data;
  logic [1:0] s_occupancy;
  logic [2:0] s_stall_cnt;
  int tests = 0, fails = 0;
  logic [31:0] q[$];
  int mcnt = 0;
  always #5 CLK = ~CLK;
  pipe_stage_reg #(.WIDTH(32), .CNTW(16)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt));
  pipe_stage_reg #(.WIDTH(32), .CNTW(3)) sdut (
    .CLK(CLK), .nRST(nRST), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt));
  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    bit push, pop;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    push = iv && q.size() < 2;
    pop = ordy && q.size() > 0;
    if (q.size() > 0 && !ordy && mcnt < 65535) mcnt++;
    @(posedge CLK);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
    end
    @(negedge CLK);
  endtask
  task automatic test_reset();
    drive(1, 32'h1, 0, 0);
    drive(1, 32'h2, 0, 0);
    tests++; if (occupancy !== 2'd2) begin fails++; $display("FAIL reset_prefill occupancy=%0d want 2", occupancy); end
    #2 nRST = 1'b0;
    q.delete(); mcnt = 0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || occupancy !== 2'd0 || stall_cnt !== 16'h0) begin
      fails++; $display("FAIL reset_async out_valid=%b in_ready=%b out_data=%h occ=%0d stall=%0d want 0 1 0 0 0", out_valid, in_ready, out_data, occupancy, stall_cnt);
    end
    @(negedge CLK);
    nRST = 1'b1;
    drive(1, 32'hDEADBEEF, 1, 0);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
      fails++; $display("FAIL reset_first out_valid=%b out_data=%h want 1 deadbeef", out_valid, out_data);
    end
    drive(0, 0, 1, 0);
  endtask
  task automatic test_stream();
    for (int i = 1; i <= 100; i++) begin
      drive(1, 32'(i), 1, 0);
      tests++;
      if (out_valid !== 1'b1 || out_data !== 32'(i) || in_ready !== 1'b1) begin
        fails++; $display("FAIL stream[%0d] out_valid=%b out_data=%h in_ready=%b want 1 %h 1", i, out_valid, out_data, in_ready, i);
      end
    end
    drive(0, 0, 1, 0);
    tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL stream_stall stall_cnt=%0d want 0", stall_cnt); end
  endtask
  task automatic test_skid();
    logic [31:0] got[$];
    drive(1, 32'hA, 1, 0);
    tests++; if (out_data !== 32'hA || occupancy !== 2'd1) begin fails++; $display("FAIL skid_a out_data=%h occ=%0d want a 1", out_data, occupancy); end
    drive(1, 32'hB, 0, 0);
    tests++;
    if (out_data !== 32'hA || occupancy !== 2'd2 || in_ready !== 1'b0) begin
      fails++; $display("FAIL skid_full out_data=%h occ=%0d in_ready=%b want a 2 0", out_data, occupancy, in_ready);
    end
    drive(1, 32'hC, 0, 0);
    tests++;
    if (out_data !== 32'hA || occupancy !== 2'd2 || in_ready !== 1'b0) begin
      fails++; $display("FAIL skid_hold out_data=%h occ=%0d in_ready=%b want a 2 0", out_data, occupancy, in_ready);
    end
    got.push_back(out_data);
    drive(1, 32'hC, 1, 0);
    if (out_valid) got.push_back(out_data);
    drive(1, 32'hC, 1, 0);
    if (out_valid) got.push_back(out_data);
    drive(0, 0, 1, 0);
    if (out_valid) got.push_back(out_data);
    tests++;
    if (got.size() != 3 || got[0] !== 32'hA || got[1] !== 32'hB || got[2] !== 32'hC) begin
      fails++; $display("FAIL skid_order got %0d entries %p want a b c", got.size(), got);
    end
  endtask
  task automatic test_flush();
    drive(1, 32'h11, 0, 0);
    drive(1, 32'h22, 0, 0);
    tests++; if (occupancy !== 2'd2) begin fails++; $display("FAIL flush_prefill occ=%0d want 2", occupancy); end
    drive(1, 32'h33, 1, 1);
    tests++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL flush out_valid=%b out_data=%h occ=%0d in_ready=%b want 0 0 0 1", out_valid, out_data, occupancy, in_ready);
    end
    drive(0, 0, 1, 0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_squash out_valid=%b out_data=%h want 0", out_valid, out_data); end
    tests++; if (stall_cnt !== 16'(mcnt)) begin fails++; $display("FAIL flush_stall stall_cnt=%0d want %0d", stall_cnt, mcnt); end
  endtask
  task automatic test_stall();
    s_in_valid = 1'b1; s_in_data = 32'h5; s_out_ready = 1'b0;
    @(posedge CLK); @(negedge CLK);
    s_in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK); @(negedge CLK);
      tests++;
      if (s_stall_cnt !== 3'((k > 7) ? 7 : k)) begin
        fails++; $display("FAIL stall_cnt[%0d] got %0d want %0d", k, s_stall_cnt, (k > 7) ? 7 : k);
      end
    end
    s_flush = 1'b1;
    @(posedge CLK); @(negedge CLK);
    s_flush = 1'b0;
    @(posedge CLK); @(negedge CLK);
    tests++;
    if (s_stall_cnt !== 3'd7 || s_out_valid !== 1'b0) begin
      fails++; $display("FAIL stall_after_flush stall=%0d out_valid=%b want 7 0", s_stall_cnt, s_out_valid);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
      tests++;
      if (occupancy !== 2'(q.size()) || out_valid !== (q.size() > 0) || in_ready !== (q.size() != 2)) begin
        fails++; $display("FAIL rand_state[%0d] occ=%0d out_valid=%b in_ready=%b want occ %0d", i, occupancy, out_valid, in_ready, q.size());
      end
      if (q.size() > 0) begin
        tests++;
        if (out_data !== q[0]) begin fails++; $display("FAIL rand_data[%0d] out_data=%h want %h", i, out_data, q[0]); end
      end
      tests++;
      if (stall_cnt !== 16'(mcnt)) begin fails++; $display("FAIL rand_stall[%0d] stall_cnt=%0d want %0d", i, stall_cnt, mcnt); end
    end
  endtask
  initial begin
    nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1; s_in_data = '0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
